// File: rtl/game_pkg.sv
// Shared types and defaults for the Space Invaders game controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package game_pkg;

  typedef enum logic [1:0] {
    GS_PLAY    = 2'd0,
    GS_WIN     = 2'd1,
    GS_LOSE    = 2'd2,
    GS_RESTART = 2'd3
  } game_state_e;

  localparam int N_ALIENS    = 5;
  localparam int N_MISSILES  = 8;
  localparam int HOLD_FRAMES = 120;

  // Score never wraps: a long winning streak pins at 255.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/missile_slot_arb.sv
// Picks the lowest free missile slot on a fire request; otherwise flags a drop.
// Latency: grant / drop registered, 1 cycle after fire_vld.
// Backpressure: none; a request with no eligible slot is dropped, never queued.
module missile_slot_arb #(
  parameter int N_MISSILES = 8
) (
  input  logic                  vga_clk_i,
  input  logic                  vga_rst_i,
  input  logic                  fire_vld,
  input  logic [N_MISSILES-1:0] busy,
  output logic [N_MISSILES-1:0] launch,
  output logic                  drop
);

  logic [N_MISSILES-1:0] free;
  logic [N_MISSILES-1:0] grant;
  logic                  found;

  // The slot granted last cycle is still shown idle by the player block, so mask it out.
  always_comb begin
    free  = ~busy & ~launch;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N_MISSILES; i++) begin
      if (free[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  // Register the one-hot launch or the drop pulse; both are single-cycle.
  always_ff @(posedge vga_clk_i or negedge vga_rst_i) begin
    if (!vga_rst_i) begin
      launch <= '0;
      drop   <= 1'b0;
    end else begin
      launch <= fire_vld ? grant : '0;
      drop   <= fire_vld & ~found;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Game flow controller: accumulates alien/missile hits per frame, commits kills at frame start, sequences PLAY/WIN/LOSE/RESTART.
// Latency: all outputs registered; commit 1 cycle after frame_start_i, launch/drop 1 cycle after fire_i.
// Backpressure: none; fires with no free slot (or outside PLAY) are dropped.
module game_ctrl
  import game_pkg::*;
#(
  parameter int N_ALIENS    = game_pkg::N_ALIENS,
  parameter int N_MISSILES  = game_pkg::N_MISSILES,
  parameter int HOLD_FRAMES = game_pkg::HOLD_FRAMES
) (
  input  logic                  vga_clk_i,
  input  logic                  vga_rst_i,
  input  logic                  frame_start_i,
  input  logic                  video_on_i,
  input  logic [N_ALIENS-1:0]   alien_active_i,
  input  logic [N_MISSILES-1:0] missile_active_i,
  input  logic [N_MISSILES-1:0] missile_busy_i,
  input  logic                  aliens_landed_i,
  input  logic                  fire_i,
  output logic [N_ALIENS-1:0]   alien_alive_o,
  output logic [N_MISSILES-1:0] missile_launch_o,
  output logic [N_MISSILES-1:0] missile_kill_o,
  output logic                  fire_drop_o,
  output logic [1:0]            game_state_o,
  output logic [7:0]            score_o,
  output logic                  restart_o
);

  localparam int HW = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES);

  game_state_e           state;
  logic [N_ALIENS-1:0]   alive;
  logic [N_ALIENS-1:0]   pend_kill;
  logic [N_MISSILES-1:0] pend_mkill;
  logic [7:0]            score;
  logic [HW-1:0]         hold_cnt;

  logic                  in_play;
  logic [N_ALIENS-1:0]   alive_hit;
  logic                  hit_vld;
  logic [N_ALIENS-1:0]   hit_kill;
  logic [N_MISSILES-1:0] hit_mkill;
  logic [N_ALIENS-1:0]   post_alive;
  logic [N_ALIENS-1:0]   commit_mask;
  logic [7:0]            kill_cnt;
  logic                  hold_done;

  // Per-pixel hit qualification and commit-time arithmetic.
  always_comb begin
    in_play     = (state == GS_PLAY);
    alive_hit   = alive & alien_active_i;
    hit_vld     = in_play & video_on_i & (|missile_active_i) & (|alive_hit);
    hit_kill    = hit_vld ? alive_hit : '0;
    hit_mkill   = hit_vld ? missile_active_i : '0;
    post_alive  = alive & ~pend_kill;
    commit_mask = pend_kill & alive;
    kill_cnt    = 8'd0;
    for (int i = 0; i < N_ALIENS; i++) begin
      kill_cnt = kill_cnt + {7'd0, commit_mask[i]};
    end
    hold_done   = (hold_cnt == HW'(HOLD_FRAMES - 1));
  end

  // Pending masks: a hit on the frame_start cycle seeds the next frame rather than the committing one.
  always_ff @(posedge vga_clk_i or negedge vga_rst_i) begin
    if (!vga_rst_i) begin
      pend_kill  <= '0;
      pend_mkill <= '0;
    end else if (!in_play) begin
      pend_kill  <= '0;
      pend_mkill <= '0;
    end else if (frame_start_i) begin
      pend_kill  <= hit_kill;
      pend_mkill <= hit_mkill;
    end else begin
      pend_kill  <= pend_kill | hit_kill;
      pend_mkill <= pend_mkill | hit_mkill;
    end
  end

  // Game FSM with frame commit, hold timer, score and restart pulse.
  always_ff @(posedge vga_clk_i or negedge vga_rst_i) begin
    if (!vga_rst_i) begin
      state          <= GS_PLAY;
      alive          <= '1;
      score          <= 8'd0;
      hold_cnt       <= '0;
      missile_kill_o <= '0;
      restart_o      <= 1'b0;
    end else begin
      missile_kill_o <= '0;
      restart_o      <= 1'b0;
      case (state)
        GS_PLAY: begin
          if (frame_start_i) begin
            alive          <= post_alive;
            missile_kill_o <= pend_mkill;
            score          <= sat_add8(score, kill_cnt);
            // Clearing the board wins even if the aliens landed on the same frame.
            if (post_alive == '0) begin
              state <= GS_WIN;
            end else if (aliens_landed_i) begin
              state <= GS_LOSE;
            end
          end
        end
        GS_WIN, GS_LOSE: begin
          if (frame_start_i) begin
            if (hold_done) begin
              state     <= GS_RESTART;
              hold_cnt  <= '0;
              restart_o <= 1'b1;
              alive     <= '1;
              if (state == GS_LOSE) begin
                score <= 8'd0;
              end
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        GS_RESTART: begin
          state <= GS_PLAY;
        end
        default: begin
          state <= GS_PLAY;
        end
      endcase
    end
  end

  missile_slot_arb #(
    .N_MISSILES(N_MISSILES)
  ) u_arb (
    .vga_clk_i(vga_clk_i),
    .vga_rst_i(vga_rst_i),
    .fire_vld (fire_i & in_play),
    .busy     (missile_busy_i),
    .launch   (missile_launch_o),
    .drop     (fire_drop_o)
  );

  assign alien_alive_o = alive;
  assign game_state_o  = state;
  assign score_o       = score;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: table of per-cycle vectors plus hand sequences for lose and mid-frame reset.
// Latency: each vector is applied, one clock edge taken, and outputs sampled 1 ns after the edge.
// Backpressure: n/a.
module tb_game_ctrl;

  logic       clk;
  logic       rst_n;
  logic       fs, von, land, fire;
  logic [4:0] aa;
  logic [7:0] ma, busy;

  logic [4:0] alive;
  logic [7:0] launch, kill, score;
  logic       drop, rst_p;
  logic [1:0] st;

  int checks   = 0;
  int failures = 0;

  game_ctrl #(
    .N_ALIENS   (5),
    .N_MISSILES (8),
    .HOLD_FRAMES(2)
  ) dut (
    .vga_clk_i       (clk),
    .vga_rst_i       (rst_n),
    .frame_start_i   (fs),
    .video_on_i      (von),
    .alien_active_i  (aa),
    .missile_active_i(ma),
    .missile_busy_i  (busy),
    .aliens_landed_i (land),
    .fire_i          (fire),
    .alien_alive_o   (alive),
    .missile_launch_o(launch),
    .missile_kill_o  (kill),
    .fire_drop_o     (drop),
    .game_state_o    (st),
    .score_o         (score),
    .restart_o       (rst_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       fs, von;
    logic [4:0] aa;
    logic [7:0] ma, busy;
    logic       land, fire;
    logic [4:0] e_alive;
    logic [1:0] e_st;
    logic [7:0] e_score, e_kill, e_launch;
    logic       e_drop, e_rst;
  } vec_t;

  vec_t tv[21];

  task automatic drive(input logic f, input logic v, input logic [4:0] a, input logic [7:0] m,
                       input logic [7:0] b, input logic l, input logic fi);
    fs = f; von = v; aa = a; ma = m; busy = b; land = l; fire = fi;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [4:0] e_alive, input logic [1:0] e_st,
                       input logic [7:0] e_score, input logic [7:0] e_kill, input logic [7:0] e_launch,
                       input logic e_drop, input logic e_rst);
    checks++;
    if ({alive, st, score, kill, launch, drop, rst_p} !==
        {e_alive, e_st, e_score, e_kill, e_launch, e_drop, e_rst}) begin
      failures++;
      $display("FAIL %s: got alive=%h st=%0d score=%0d kill=%h launch=%h drop=%b restart=%b ; want alive=%h st=%0d score=%0d kill=%h launch=%h drop=%b restart=%b",
               name, alive, st, score, kill, launch, drop, rst_p,
               e_alive, e_st, e_score, e_kill, e_launch, e_drop, e_rst);
    end
  endtask

  initial begin
    //        fs    von   aa      ma     busy   land  fire  | alive  st    score  kill   launch drop  rst
    tv[0]  = '{1'b1, 1'b0, 5'h00, 8'h00, 8'h00, 1'b0, 1'b0, 5'h1F, 2'd0, 8'd0, 8'h00, 8'h00, 1'b0, 1'b0};
    tv[1]  = '{1'b0, 1'b1, 5'h04, 8'h20, 8'h00, 1'b0, 1'b0, 5'h1F, 2'd0, 8'd0, 8'h00, 8'h00, 1'b0, 1'b0};
    tv[2]  = '{1'b0, 1'b1, 5'h04, 8'h20, 8'h00, 1'b0, 1'b0, 5'h1F, 2'd0, 8'd0, 8'h00, 8'h00, 1'b0, 1'b0};
    tv[3]  = '{1'b0, 1'b1, 5'h04, 8'h20, 8'h00, 1'b0, 1'b0, 5'h1F, 2'd0, 8'd0, 8'h00, 8'h00, 1'b0, 1'b0};
    tv[4]  = '{1'b0, 1'b1, 5'h04, 8'h00, 8'h00, 1'b0, 1'b0, 5'h1F, 2'd0, 8'd0, 8'h00, 8'h00, 1'b0, 1'b0};
    tv[5]  = '{1'b1, 1'b0, 5'h00, 8'h00, 8'h00, 1'b0, 1'b0, 5'h1B, 2'd0, 8'd1, 8'h20, 8'h00, 1'b0, 1'b0};
    tv[6]  = '{1'b0, 1'b0, 5'h00, 8'h00, 8'h00, 1'b0, 1'b0, 5'h1B, 2'd0, 8'd1, 8'h00, 8'h00, 1'b0, 1'b0};
    tv[7]  = '{1'b0, 1'b0, 5'h00, 8'h00, 8'h07, 1'b0, 1'b1, 5'h1B, 2'd0, 8'd1, 8'h00, 8'h08, 1'b0, 1'b0};
    tv[8]  = '{1'b0, 1'b0, 5'h00, 8'h00, 8'h07, 1'b0, 1'b1, 5'h1B, 2'd0, 8'd1, 8'h00, 8'h10, 1'b0, 1'b0};
    tv[9]  = '{1'b0, 1'b0, 5'h00, 8'h00, 8'h07, 1'b0, 1'b0, 5'h1B, 2'd0, 8'd1, 8'h00, 8'h00, 1'b0, 1'b0};
    tv[10] = '{1'b0, 1'b0, 5'h00, 8'h00, 8'hFF, 1'b0, 1'b1, 5'h1B, 2'd0, 8'd1, 8'h00, 8'h00, 1'b1, 1'b0};
    tv[11] = '{1'b0, 1'b0, 5'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 5'h1B, 2'd0, 8'd1, 8'h00, 8'h00, 1'b0, 1'b0};
    tv[12] = '{1'b0, 1'b1, 5'h04, 8'h01, 8'h00, 1'b0, 1'b0, 5'h1B, 2'd0, 8'd1, 8'h00, 8'h00, 1'b0, 1'b0};
    tv[13] = '{1'b1, 1'b0, 5'h00, 8'h00, 8'h00, 1'b0, 1'b0, 5'h1B, 2'd0, 8'd1, 8'h00, 8'h00, 1'b0, 1'b0};
    tv[14] = '{1'b0, 1'b1, 5'h1B, 8'h01, 8'h00, 1'b1, 1'b0, 5'h1B, 2'd0, 8'd1, 8'h00, 8'h00, 1'b0, 1'b0};
    tv[15] = '{1'b1, 1'b0, 5'h00, 8'h00, 8'h00, 1'b1, 1'b0, 5'h00, 2'd1, 8'd5, 8'h01, 8'h00, 1'b0, 1'b0};
    tv[16] = '{1'b0, 1'b0, 5'h00, 8'h00, 8'h00, 1'b0, 1'b1, 5'h00, 2'd1, 8'd5, 8'h00, 8'h00, 1'b0, 1'b0};
    tv[17] = '{1'b1, 1'b0, 5'h00, 8'h00, 8'h00, 1'b0, 1'b0, 5'h00, 2'd1, 8'd5, 8'h00, 8'h00, 1'b0, 1'b0};
    tv[18] = '{1'b0, 1'b1, 5'h1F, 8'hFF, 8'h00, 1'b0, 1'b0, 5'h00, 2'd1, 8'd5, 8'h00, 8'h00, 1'b0, 1'b0};
    tv[19] = '{1'b1, 1'b0, 5'h00, 8'h00, 8'h00, 1'b0, 1'b0, 5'h1F, 2'd3, 8'd5, 8'h00, 8'h00, 1'b0, 1'b1};
    tv[20] = '{1'b0, 1'b0, 5'h00, 8'h00, 8'h00, 1'b0, 1'b1, 5'h1F, 2'd0, 8'd5, 8'h00, 8'h00, 1'b0, 1'b0};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 5'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    check("reset_state", 5'h1F, 2'd0, 8'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    check("after_release", 5'h1F, 2'd0, 8'd0, 8'h00, 8'h00, 1'b0, 1'b0);

    // Table: empty frame, 3-pixel hit, launches, drop, dead-alien overlap, win with landing, hold, restart.
    for (int i = 0; i < 21; i++) begin
      drive(tv[i].fs, tv[i].von, tv[i].aa, tv[i].ma, tv[i].busy, tv[i].land, tv[i].fire);
      tick();
      check($sformatf("vec%0d", i), tv[i].e_alive, tv[i].e_st, tv[i].e_score,
            tv[i].e_kill, tv[i].e_launch, tv[i].e_drop, tv[i].e_rst);
    end

    // Lose with 3 aliens alive: fires ignored during hold, score cleared at restart.
    drive(1'b0, 1'b1, 5'h03, 8'h02, 8'h00, 1'b0, 1'b0); tick();
    check("lose_accum", 5'h1F, 2'd0, 8'd5, 8'h00, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 5'h00, 8'h00, 8'h00, 1'b1, 1'b0); tick();
    check("lose_commit", 5'h1C, 2'd2, 8'd7, 8'h02, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 5'h00, 8'h00, 8'h00, 1'b0, 1'b1); tick();
    check("lose_fire_ignored", 5'h1C, 2'd2, 8'd7, 8'h00, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 5'h1C, 8'h01, 8'h00, 1'b0, 1'b0); tick();
    check("lose_hold1", 5'h1C, 2'd2, 8'd7, 8'h00, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 5'h00, 8'h00, 8'h00, 1'b0, 1'b0); tick();
    check("lose_restart", 5'h1F, 2'd3, 8'd0, 8'h00, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 5'h00, 8'h00, 8'h00, 1'b0, 1'b0); tick();
    check("lose_replay", 5'h1F, 2'd0, 8'd0, 8'h00, 8'h00, 1'b0, 1'b0);

    // Async reset mid-frame with a pending hit and a live launch pulse.
    drive(1'b0, 1'b1, 5'h01, 8'h01, 8'h00, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 5'h00, 8'h00, 8'h00, 1'b0, 1'b0); tick();
    check("pre_rst_commit", 5'h1E, 2'd0, 8'd1, 8'h01, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 5'h02, 8'h02, 8'h00, 1'b0, 1'b1); tick();
    check("pre_rst_launch", 5'h1E, 2'd0, 8'd1, 8'h00, 8'h01, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 5'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("async_reset", 5'h1F, 2'd0, 8'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 5'h00, 8'h00, 8'h00, 1'b0, 1'b0); tick();
    check("post_rst_no_kill", 5'h1F, 2'd0, 8'd0, 8'h00, 8'h00, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Sequential game controller for the VGA Space Invaders datapath. It sits between the sprite generators and the `vga_top` pixel mux.
- Accumulates per-pixel alien/missile overlaps during each visible frame and commits kills at the frame boundary.
- Allocates missile slots on fire requests.
- Sequences the PLAY / WIN / LOSE / RESTART game flow, replacing the combinational latch-based hit logic in the display path.

## Interface
- `N_ALIENS`, 5, number of alien sprites tracked.
- `N_MISSILES`, 8, number of missile slots.
- `HOLD_FRAMES`, 120, frames the WIN/LOSE screen is held before restart (≥1).
- `vga_clk_i`  in  1  pixel clock; the only clock.
- `vga_rst_i`  in  1  reset, asynchronous assert, active-low.
- `frame_start_i`  in  1  one-cycle pulse at start of vertical blank, from `dtg`.
- `video_on_i`  in  1  visible-region qualifier from `dtg`.
- `alien_active_i`  in  N_ALIENS  per-pixel alien sprite hit.
- `missile_active_i`  in  N_MISSILES  per-pixel missile sprite hit.
- `missile_busy_i`  in  N_MISSILES  slot in flight, from `player`.
- `aliens_landed_i`  in  1  level; aliens reached player row.
- `fire_i`  in  1  one-cycle fire request, already debounced.
- `alien_alive_o`  out  N_ALIENS  alive mask, gates alien drawing.
- `missile_launch_o`  out  N_MISSILES  one-hot launch pulse.
- `missile_kill_o`  out  N_MISSILES  one-cycle retire pulse for missiles that scored.
- `fire_drop_o`  out  1  pulse; fire rejected, all slots busy.
- `game_state_o`  out  2  `game_state_e`; also the display mux select.
- `score_o`  out  8  saturating kill count.
- `restart_o`  out  1  one-cycle pulse to reset sprite positions.

## Operation
- **Reset values:** state `GS_PLAY`, `alien_alive_o` all ones, `score_o`=0, hold counter 0, pending masks 0, all pulse outputs 0.
- **Hit accumulation:** every cycle with `video_on_i`=1 and state `GS_PLAY`:
  - For each alive alien *i* with `alien_active_i[i]`=1 and any `missile_active_i[j]`=1, set `pend_kill[i]`.
  - Set `pend_mkill[j]` for every such active *j*.
  - Overlaps with dead aliens are ignored.
- **Commit on `frame_start_i` (PLAY):**
  - `alive <= alive & ~pend_kill`.
  - `missile_kill_o <= pend_mkill` for exactly one cycle.
  - `score <= min(255, score + popcount(pend_kill & alive))`.
  - Pending masks cleared. A hit qualifying in the same cycle as `frame_start_i` goes into the next frame's masks.
- **Transitions** (evaluated at commit, using post-commit alive):
  - alive==0 → `GS_WIN`. Win has priority over simultaneous `aliens_landed_i`.
  - Else `aliens_landed_i`=1 → `GS_LOSE`.
  - Else stay `GS_PLAY`.
- **`GS_WIN` / `GS_LOSE`:**
  - Hold counter increments per `frame_start_i`.
  - On reaching `HOLD_FRAMES` → `GS_RESTART`, counter cleared.
  - Hits, fires and `aliens_landed_i` are ignored.
- **`GS_RESTART`** (one cycle):
  - `restart_o`=1, alive set to all ones, pending masks cleared.
  - Score cleared if arriving from LOSE, kept if from WIN.
  - Next state `GS_PLAY`.
- **Missile arbitration:**
  - `fire_i` in `GS_PLAY` selects the lowest index *j* with `missile_busy_i[j]`=0 that was not launched in the previous cycle.
  - `missile_launch_o[j]` pulses one cycle later.
  - No eligible slot → `fire_drop_o` pulses instead.
  - `fire_i` outside PLAY produces neither pulse.
- **Async reset mid-frame:** all state returns to reset values immediately. Pulses deassert without completing.

## Timing
- Commit latency: state, alive, score and `missile_kill_o` update on the first edge after `frame_start_i` is sampled high (registered, 1 cycle).
- `missile_launch_o` / `fire_drop_o`: 1 cycle after `fire_i`.
- `restart_o` asserts the cycle after the final hold frame's `frame_start_i`. `GS_PLAY` follows 1 cycle later.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- `game_pkg`:
  - `typedef enum logic [1:0] game_state_e {GS_PLAY=0, GS_WIN=1, GS_LOSE=2, GS_RESTART=3}`.
  - Default constants `N_ALIENS`, `N_MISSILES`, `HOLD_FRAMES`.
- Sub-module `missile_slot_arb`: lowest-index free-slot picker with one-cycle recent-launch exclusion mask. Registered one-hot grant and drop pulse.
- Top `game_ctrl` holds the FSM, pending masks, alive mask, score and hold counter.

## Test plan
- Reset release, then one frame with no overlaps → alive=5'b11111, score=0, state=PLAY, `missile_kill_o`=0.
- Alien 2 and missile 5 overlap for 3 pixels in one frame → at next `frame_start_i`: alive=5'b11011, score=1, `missile_kill_o`=8'b0010_0000 for exactly 1 cycle.
- `missile_busy_i`=8'b0000_0111, `fire_i` pulses at t and t+1 → launch 8'b0000_1000 at t+1 and 8'b0001_0000 at t+2. Then busy=8'hFF, fire → `fire_drop_o` pulse, no launch.
- Last alien killed in the same frame that `aliens_landed_i`=1 → state WIN. After `HOLD_FRAMES`=2 frame_starts, `restart_o` pulse; alive=all ones; score retained (5).
- `aliens_landed_i`=1 at a commit with 3 aliens alive → LOSE. Fires ignored. After hold, restart with score=0.
- Assert `vga_rst_i`=0 mid-frame with pending hits → all outputs at reset values the same cycle. No kill committed at the next `frame_start_i`.
